// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared state encoding, screen constants and playfield defaults for the pong sequencer
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

  localparam int H_RES = 640;
  localparam int V_RES = 480;

  // Default playfield: an 8-pixel wall band top and bottom, scoring lines 32 pixels in from each edge
  localparam int DEF_BALL_SIZE = 8;
  localparam int DEF_PADDLE_H  = 64;
  localparam int DEF_PADDLE_XL = 40;
  localparam int DEF_PADDLE_XR = H_RES - 40;
  localparam int DEF_WALL_TOP  = 8;
  localparam int DEF_WALL_BOT  = V_RES - 8;
  localparam int DEF_OUT_L     = 32;
  localparam int DEF_OUT_R     = H_RES - 32;

  localparam int TMR_W = 16;

  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return (s == 4'hf) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - frame-tick divider with load value, clear, completion strobe and one-cycle pulse
module step_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clear,
  input  logic         tick,
  input  logic [W-1:0] load,
  output logic         done,
  output logic         pulse
);

  logic [W-1:0] cnt;
  logic [W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt} + {{W{1'b0}}, 1'b1};

  // done marks the tick that completes the period; >= keeps it safe when load shrinks mid-count
  assign done = en && !clear && tick && (cnt_inc >= {1'b0, load});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= done;
      if (clear || done) begin
        cnt <= '0;
      end else if (en && tick) begin
        cnt <= cnt_inc[W-1:0];
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong sequencer: ball stepping, wall/paddle bounces, scoring and game FSM
// Optional SPEEDUP_EN: each paddle hit shortens the ball step period until the next serve.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int STEP_DIV     = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int WIN_SCORE    = 7,
  parameter int BALL_SIZE    = DEF_BALL_SIZE,
  parameter int PADDLE_H     = DEF_PADDLE_H,
  parameter int PADDLE_XL    = DEF_PADDLE_XL,
  parameter int PADDLE_XR    = DEF_PADDLE_XR,
  parameter int WALL_TOP     = DEF_WALL_TOP,
  parameter int WALL_BOT     = DEF_WALL_BOT,
  parameter int OUT_L        = DEF_OUT_L,
  parameter int OUT_R        = DEF_OUT_R
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] ball_x,
  input  logic [8:0] ball_y,
  input  logic [8:0] pad_l_y,
  input  logic [8:0] pad_r_y,
  output logic       ball_en,
  output logic       ball_hold,
  output logic       v_col,
  output logic       h_col,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic [2:0] state
);

  localparam logic [10:0] BS    = 11'(BALL_SIZE);
  localparam logic [10:0] PH    = 11'(PADDLE_H);
  localparam logic [10:0] XL    = 11'(PADDLE_XL);
  localparam logic [10:0] XR    = 11'(PADDLE_XR);
  localparam logic [10:0] WT    = 11'(WALL_TOP);
  localparam logic [10:0] WB    = 11'(WALL_BOT);
  localparam logic [10:0] OL    = 11'(OUT_L);
  localparam logic [10:0] ORL   = 11'(OUT_R);
  localparam logic [3:0]  WIN   = 4'(WIN_SCORE);
  localparam logic [TMR_W-1:0] STEP_LD  = TMR_W'(STEP_DIV);
  localparam logic [TMR_W-1:0] SERVE_LD = TMR_W'(SERVE_FRAMES);
  localparam logic [TMR_W-1:0] POINT_LD = TMR_W'(POINT_FRAMES);

  game_state_t st, st_nxt;

  logic             in_play, in_serve, in_point;
  logic             chk, eval, start_ok, won;
  logic             step_pulse, step_done_unused;
  logic             serve_done, serve_pulse_unused;
  logic             point_done, point_pulse_unused;
  logic [TMR_W-1:0] step_load;
  logic [10:0]      bx, by, by_bot, pl, pr;
  logic             out_l, out_r, out_any;
  logic             ovl_l, ovl_r, v_cond, h_cond, v_fire, h_fire;
  logic [1:0]       v_hold, h_hold;

  assign in_play  = (st == ST_PLAY);
  assign in_serve = (st == ST_SERVE);
  assign in_point = (st == ST_POINT);
  assign start_ok = start && ((st == ST_IDLE) || (st == ST_OVER));
  assign won      = (score_l == WIN) || (score_r == WIN);

  // ---------------------------------------------------------------- timers
  step_timer #(.W(TMR_W)) u_step (
    .clk   (clk),
    .reset (reset),
    .en    (in_play),
    .clear (!in_play),
    .tick  (frame_tick),
    .load  (step_load),
    .done  (step_done_unused),
    .pulse (step_pulse)
  );

  step_timer #(.W(TMR_W)) u_serve (
    .clk   (clk),
    .reset (reset),
    .en    (in_serve),
    .clear (!in_serve),
    .tick  (frame_tick),
    .load  (SERVE_LD),
    .done  (serve_done),
    .pulse (serve_pulse_unused)
  );

  step_timer #(.W(TMR_W)) u_point (
    .clk   (clk),
    .reset (reset),
    .en    (in_point),
    .clear (!in_point),
    .tick  (frame_tick),
    .load  (POINT_LD),
    .done  (point_done),
    .pulse (point_pulse_unused)
  );

  // A step that completes on the edge leaving PLAY must not reach the ball
  assign ball_en = step_pulse && in_play;

`ifdef SPEEDUP_EN
  logic [TMR_W-1:0] div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= STEP_LD;
    end else if (in_serve) begin
      div <= STEP_LD;
    end else if (h_fire && (div > TMR_W'(1))) begin
      div <= div - TMR_W'(1);
    end
  end

  assign step_load = div;
`else
  assign step_load = STEP_LD;
`endif

  // ---------------------------------------------------------------- contact detection
  assign bx     = {1'b0, ball_x};
  assign by     = {2'b0, ball_y};
  assign pl     = {2'b0, pad_l_y};
  assign pr     = {2'b0, pad_r_y};
  assign by_bot = by + BS;

  assign out_l   = bx < OL;
  assign out_r   = bx > ORL;
  assign out_any = out_l || out_r;

  assign ovl_l  = (by_bot > pl) && (by < pl + PH);
  assign ovl_r  = (by_bot > pr) && (by < pr + PH);
  assign v_cond = (by <= WT) || (by_bot >= WB);
  assign h_cond = ((bx <= XL) && ovl_l) || ((bx + BS >= XR) && ovl_r);

  // Coordinates are only trusted on the cycle after a step, once the ball has moved
  assign eval   = chk && in_play;
  assign v_fire = eval && !out_any && (v_hold == 2'd0) && v_cond;
  assign h_fire = eval && !out_any && (h_hold == 2'd0) && h_cond;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk     <= 1'b0;
      v_col   <= 1'b0;
      h_col   <= 1'b0;
      v_hold  <= 2'd0;
      h_hold  <= 2'd0;
      score_l <= 4'd0;
      score_r <= 4'd0;
    end else begin
      chk   <= ball_en;
      v_col <= v_fire;
      h_col <= h_fire;

      if (!in_play) begin
        v_hold <= 2'd0;
        h_hold <= 2'd0;
      end else if (eval && !out_any) begin
        if (v_fire)               v_hold <= 2'd2;
        else if (v_hold != 2'd0)  v_hold <= v_hold - 2'd1;
        if (h_fire)               h_hold <= 2'd2;
        else if (h_hold != 2'd0)  h_hold <= h_hold - 2'd1;
      end

      if (start_ok) begin
        score_l <= 4'd0;
        score_r <= 4'd0;
      end else if (eval && out_l) begin
        score_r <= score_inc(score_r);
      end else if (eval && out_r) begin
        score_l <= score_inc(score_l);
      end
    end
  end

  // ---------------------------------------------------------------- game FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= ST_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:  if (start)          st_nxt = ST_SERVE;
      ST_SERVE: if (serve_done)     st_nxt = ST_PLAY;
      ST_PLAY:  if (eval && out_any) st_nxt = ST_POINT;
      ST_POINT: if (point_done)     st_nxt = won ? ST_OVER : ST_SERVE;
      ST_OVER:  if (start)          st_nxt = ST_SERVE;
      default:                      st_nxt = ST_IDLE;
    endcase
  end

  assign ball_hold = !in_play;
  assign game_over = (st == ST_OVER);
  assign state     = st;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - randomized bench for pong_game_ctrl against an event-level game model
module tb_pong_game_ctrl;

  localparam int STEP_DIV     = 2;
  localparam int SERVE_FRAMES = 60;
  localparam int POINT_FRAMES = 30;
  localparam int WIN_SCORE    = 7;
  localparam int BALL_SIZE    = 8;
  localparam int PADDLE_H     = 64;
  localparam int PADDLE_XL    = 40;
  localparam int PADDLE_XR    = 600;
  localparam int WALL_TOP     = 8;
  localparam int WALL_BOT     = 472;
  localparam int OUT_L        = 32;
  localparam int OUT_R        = 608;

  localparam int IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [8:0] pad_l_y;
  logic [8:0] pad_r_y;
  logic       ball_en;
  logic       ball_hold;
  logic       v_col;
  logic       h_col;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       game_over;
  logic [2:0] state;

  pong_game_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .pad_l_y    (pad_l_y),
    .pad_r_y    (pad_r_y),
    .ball_en    (ball_en),
    .ball_hold  (ball_hold),
    .v_col      (v_col),
    .h_col      (h_col),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_over  (game_over),
    .state      (state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %04h expected %04h at %0t", tag, got, exp, $time);
    end
  endtask

  // Game model: phase, frames seen in the phase, ticks since the last ball step, scores,
  // remaining suppressed checks per bounce axis, and what the outputs should show this cycle
  int m_st, m_frames, m_steps, m_div, m_sl, m_sr, m_vskip, m_hskip;
  bit m_en, m_chk, m_v, m_h;

  int dir_x  [8] = '{320, 320, 320,  40,  40, 320,  40, 20};
  int dir_y  [8] = '{  4,   4, 200, 100, 100, 200, 100,  4};
  int dir_pl [8] = '{ 80,  80,  80,  80, 200,  80, 200, 80};
  int dir_idx = 0;
  bit go_seen = 1'b0;

  task automatic model_reset();
    m_st = IDLE; m_frames = 0; m_steps = 0; m_div = STEP_DIV;
    m_sl = 0; m_sr = 0; m_vskip = 0; m_hskip = 0;
    m_en = 0; m_chk = 0; m_v = 0; m_h = 0;
  endtask

  function automatic logic [15:0] exp_outs();
    return {3'(m_st), m_en, (m_st != PLAY), m_v, m_h, (m_st == OVER), 4'(m_sl), 4'(m_sr)};
  endfunction

  function automatic logic [15:0] dut_outs();
    return {state, ball_en, ball_hold, v_col, h_col, game_over, score_l, score_r};
  endfunction

  task automatic model_step(input bit tk, input bit go, input int x, input int y,
                            input int pl, input int pr);
    int nst;
    bit n_en, n_v, n_h, wall, pad;
    nst = m_st; n_en = 0; n_v = 0; n_h = 0;
    case (m_st)
      IDLE, OVER: begin
        if (go) begin
          nst = SERVE; m_sl = 0; m_sr = 0; m_frames = 0; m_div = STEP_DIV;
        end
      end
      SERVE: begin
        if (tk) begin
          m_frames++;
          if (m_frames == SERVE_FRAMES) begin
            nst = PLAY; m_frames = 0; m_steps = 0; m_vskip = 0; m_hskip = 0;
          end
        end
      end
      PLAY: begin
        if (tk) begin
          m_steps++;
          if (m_steps >= m_div) begin
            n_en = 1; m_steps = 0;
          end
        end
        if (m_chk) begin
          if (x < OUT_L || x > OUT_R) begin
            if (x < OUT_L) m_sr = (m_sr < 15) ? m_sr + 1 : 15;
            else           m_sl = (m_sl < 15) ? m_sl + 1 : 15;
            nst = POINT; m_frames = 0; n_en = 0;
          end else begin
            wall = (y <= WALL_TOP) || (y + BALL_SIZE >= WALL_BOT);
            pad  = (x <= PADDLE_XL && y + BALL_SIZE > pl && y < pl + PADDLE_H) ||
                   (x + BALL_SIZE >= PADDLE_XR && y + BALL_SIZE > pr && y < pr + PADDLE_H);
            if (m_vskip > 0) m_vskip--;
            else if (wall) begin n_v = 1; m_vskip = 2; end
            if (m_hskip > 0) m_hskip--;
            else if (pad) begin n_h = 1; m_hskip = 2; end
`ifdef SPEEDUP_EN
            if (n_h && m_div > 1) m_div--;
`endif
          end
        end
      end
      POINT: begin
        if (tk) begin
          m_frames++;
          if (m_frames == POINT_FRAMES) begin
            nst = (m_sl == WIN_SCORE || m_sr == WIN_SCORE) ? OVER : SERVE;
            m_frames = 0; m_div = STEP_DIV;
          end
        end
      end
      default: nst = IDLE;
    endcase
    m_chk = m_en;
    m_en  = n_en;
    m_v   = n_v;
    m_h   = n_h;
    m_st  = nst;
  endtask

  task automatic pick_ball();
    int r, x, y, pl, pr;
    if (dir_idx < 8) begin
      x = dir_x[dir_idx]; y = dir_y[dir_idx]; pl = dir_pl[dir_idx]; pr = 80;
      dir_idx++;
    end else begin
      r = $urandom_range(0, 99);
      if (r < 8)       x = $urandom_range(0, 31);
      else if (r < 16) x = $urandom_range(609, 639);
      else if (r < 30) x = $urandom_range(32, 44);
      else if (r < 44) x = $urandom_range(588, 608);
      else             x = $urandom_range(45, 587);
      r = $urandom_range(0, 99);
      if (r < 15)      y = $urandom_range(0, 10);
      else if (r < 30) y = $urandom_range(460, 471);
      else             y = $urandom_range(0, 471);
      pl = $urandom_range(0, 1) ? ((y > 60) ? y - $urandom_range(0, 60) : 0) : $urandom_range(0, 416);
      pr = $urandom_range(0, 1) ? ((y > 60) ? y - $urandom_range(0, 60) : 0) : $urandom_range(0, 416);
    end
    ball_x  = 10'(x);
    ball_y  = 9'(y);
    pad_l_y = 9'(pl);
    pad_r_y = 9'(pr);
  endtask

  // One clock: compare at the falling edge, drive next inputs, advance the model across the rising edge
  task automatic cycle();
    check_val("outs", dut_outs(), exp_outs());
    if (game_over) go_seen = 1'b1;
    frame_tick = ($urandom_range(0, 1) == 0);
    start      = ($urandom_range(0, 7) == 0);
    if (m_en) pick_ball();
    model_step(frame_tick, start, int'(ball_x), int'(ball_y), int'(pad_l_y), int'(pad_r_y));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1; frame_tick = 1'b0; start = 1'b0;
    ball_x = 10'd320; ball_y = 9'd240; pad_l_y = 9'd200; pad_r_y = 9'd200;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_outs", dut_outs(), exp_outs());
    reset = 1'b0;

    for (int i = 0; i < 20000; i++) cycle();
    check_val("game_over_seen", 16'(go_seen), 16'd1);

    n = 0;
    while (m_st != PLAY && n < 3000) begin
      cycle();
      n++;
    end
    check_val("reach_play", 16'(state), 16'(PLAY));
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_val("async_reset", dut_outs(), exp_outs());
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 300; i++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
